battle_board_ctrl: RTL and testbench

- Parametrised successor of the fixed 7x5 placement/attack board logic.
- Holds the ship map and the attack map for an ROWS x COLS board, moves an attack cursor, and resolves each shot as hit, miss or repeat.
- Enforces a shot budget, flags win/loss, and drives the column-scanned LED matrix.
- Sits between the debounced buttons and the matrix/RGB/7-seg output muxes.

---
 rtl/battle_pkg.sv | 26 ++
 rtl/battle_board_ctrl_if.sv | 30 +++
 rtl/board_scan_driver.sv | 49 ++++
 rtl/battle_board_ctrl.sv | 155 +++++++++++++++
 tb/tb_battle_board_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/battle_pkg.sv
// Shared types and helpers for the battleship board controller.
package battle_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PLAY,
      ST_CHECK,
      ST_WON,
      ST_LOST
   } state_t;

   typedef enum logic [1:0] {
      RES_NONE   = 2'b00,
      RES_MISS   = 2'b01,
      RES_HIT    = 2'b10,
      RES_REPEAT = 2'b11
   } result_t;

   localparam int SHOT_W = 8;

   // Linear cell index used by the ship/hit/miss maps: column-major.
   function automatic int cell_idx(input int row, input int col, input int rows);
      return col * rows + row;
   endfunction

endpackage

// File: rtl/battle_board_ctrl_if.sv
// Button/strobe inputs and display/status outputs of the board controller.
interface battle_board_ctrl_if #(
   parameter int ROWS = 7,
   parameter int COLS = 5
);
   logic [ROWS*COLS-1:0]      ship_map;
   logic                      load_map;
   logic                      btn_next;
   logic                      btn_fire;
   logic                      show_ships;
   logic                      scan_tick;
   logic [COLS-1:0]           m_col;
   logic [ROWS-1:0]           m_line;
   logic [$clog2(ROWS)-1:0]   cur_row;
   logic [$clog2(COLS)-1:0]   cur_col;
   logic [1:0]                result;
   logic [7:0]                shots_left;
   logic                      win;
   logic                      lost;

   modport master (
      output ship_map, load_map, btn_next, btn_fire, show_ships, scan_tick,
      input  m_col, m_line, cur_row, cur_col, result, shots_left, win, lost
   );

   modport slave (
      input  ship_map, load_map, btn_next, btn_fire, show_ships, scan_tick,
      output m_col, m_line, cur_row, cur_col, result, shots_left, win, lost
   );
endinterface

// File: rtl/board_scan_driver.sv
// Column-scanned LED matrix driver: column counter, one-hot column select
// and active-low line drive taken from either the ship or the hit map.
module board_scan_driver #(
   parameter int ROWS = 7,
   parameter int COLS = 5
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 scan_tick,
   input  logic                 show_ships,
   input  logic [ROWS*COLS-1:0] ship_bits,
   input  logic [ROWS*COLS-1:0] hit_bits,
   output logic [COLS-1:0]      m_col,
   output logic [ROWS-1:0]      m_line
);
   localparam int CW = $clog2(COLS);

   logic [CW-1:0]        col_q;
   logic [ROWS*COLS-1:0] src;
   logic [COLS-1:0]      col_hot;
   logic [ROWS-1:0]      line_n;

   // Column counter advances on each scan tick, wrapping at the last column.
   always_ff @(posedge clk) begin
      if (clr)
         col_q <= '0;
      else if (scan_tick)
         col_q <= (col_q == CW'(COLS-1)) ? '0 : col_q + CW'(1);
   end

   // Decode the selected column and pick its slice of the displayed map.
   always_comb begin
      src     = show_ships ? ship_bits : hit_bits;
      col_hot = COLS'(1) << col_q;
      line_n  = ~src[int'(col_q)*ROWS +: ROWS];
   end

   // Register the matrix drive; reset shows column 0 of empty maps.
   always_ff @(posedge clk) begin
      if (clr) begin
         m_col  <= COLS'(1);
         m_line <= '1;
      end else begin
         m_col  <= col_hot;
         m_line <= line_n;
      end
   end

endmodule

// File: rtl/battle_board_ctrl.sv
// Battleship board controller: ship/attack maps, attack cursor, shot
// resolution with a shot budget, win/loss flags and matrix scan.
//
// state    | meaning
// ---------+--------------------------------------------
// ST_IDLE  | no game loaded, waiting for load_map
// ST_PLAY  | cursor moves, fire latches the target cell
// ST_CHECK | resolve the latched shot (one cycle)
// ST_WON   | every ship cell hit; only load_map accepted
// ST_LOST  | budget spent without a win; only load_map accepted
module battle_board_ctrl
   import battle_pkg::*;
#(
   parameter int ROWS      = 7,
   parameter int COLS      = 5,
   parameter int MAX_SHOTS = 15
) (
   input  logic          clk,
   input  logic          clr,
   battle_board_ctrl_if.slave brd
);
   localparam int N     = ROWS * COLS;
   localparam int IDX_W = $clog2(N);
   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);

   state_t              state_q, state_n;
   logic [N-1:0]        ship_q, ship_n;
   logic [N-1:0]        hit_q, hit_n;
   logic [N-1:0]        miss_q, miss_n;
   logic [SHOT_W-1:0]   shots_q, shots_n;
   result_t             result_q, result_n;
   logic [RW-1:0]       row_q, row_n;
   logic [CW-1:0]       col_q, col_n;
   logic [IDX_W-1:0]    idx_q, idx_n;
   logic                win_q, lost_q;

   // State register.
   always_ff @(posedge clk) begin
      if (clr)
         state_q <= ST_IDLE;
      else
         state_q <= state_n;
   end

   // Next-state and datapath update: restart, cursor moves, shot resolution.
   always_comb begin
      state_n  = state_q;
      ship_n   = ship_q;
      hit_n    = hit_q;
      miss_n   = miss_q;
      shots_n  = shots_q;
      result_n = result_q;
      row_n    = row_q;
      col_n    = col_q;
      idx_n    = idx_q;

      if (brd.load_map) begin
         state_n  = ST_PLAY;
         ship_n   = brd.ship_map;
         hit_n    = '0;
         miss_n   = '0;
         shots_n  = SHOT_W'(MAX_SHOTS);
         result_n = RES_NONE;
         row_n    = '0;
         col_n    = '0;
      end else begin
         case (state_q)
            ST_PLAY: begin
               if (brd.btn_fire) begin
                  idx_n   = IDX_W'(cell_idx(int'(row_q), int'(col_q), ROWS));
                  state_n = ST_CHECK;
               end else if (brd.btn_next) begin
                  if (row_q == RW'(ROWS-1)) begin
                     row_n = '0;
                     col_n = (col_q == CW'(COLS-1)) ? '0 : col_q + CW'(1);
                  end else begin
                     row_n = row_q + RW'(1);
                  end
               end
            end
            ST_CHECK: begin
               if (hit_q[idx_q] || miss_q[idx_q]) begin
                  result_n = RES_REPEAT;
               end else if (ship_q[idx_q]) begin
                  hit_n[idx_q] = 1'b1;
                  result_n     = RES_HIT;
                  shots_n      = (shots_q == '0) ? '0 : shots_q - SHOT_W'(1);
               end else begin
                  miss_n[idx_q] = 1'b1;
                  result_n      = RES_MISS;
                  shots_n       = (shots_q == '0) ? '0 : shots_q - SHOT_W'(1);
               end
               // An empty ship map can never be won.
               if (ship_q != '0 && (hit_n & ship_q) == ship_q)
                  state_n = ST_WON;
               else if (shots_n == '0)
                  state_n = ST_LOST;
               else
                  state_n = ST_PLAY;
            end
            default: ;
         endcase
      end
   end

   // Game data registers and registered status flags.
   always_ff @(posedge clk) begin
      if (clr) begin
         ship_q   <= '0;
         hit_q    <= '0;
         miss_q   <= '0;
         shots_q  <= '0;
         result_q <= RES_NONE;
         row_q    <= '0;
         col_q    <= '0;
         idx_q    <= '0;
         win_q    <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         ship_q   <= ship_n;
         hit_q    <= hit_n;
         miss_q   <= miss_n;
         shots_q  <= shots_n;
         result_q <= result_n;
         row_q    <= row_n;
         col_q    <= col_n;
         idx_q    <= idx_n;
         win_q    <= (state_n == ST_WON);
         lost_q   <= (state_n == ST_LOST);
      end
   end

   assign brd.cur_row    = row_q;
   assign brd.cur_col    = col_q;
   assign brd.result     = result_q;
   assign brd.shots_left = shots_q;
   assign brd.win        = win_q;
   assign brd.lost       = lost_q;

   board_scan_driver #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_scan (
      .clk        (clk),
      .clr        (clr),
      .scan_tick  (brd.scan_tick),
      .show_ships (brd.show_ships),
      .ship_bits  (ship_q),
      .hit_bits   (hit_q),
      .m_col      (brd.m_col),
      .m_line     (brd.m_line)
   );

endmodule

// File: tb/tb_battle_board_ctrl.sv
// Testbench for battle_board_ctrl: directed vector table, hand-written
// timing/reset sequences and randomized operations against a board model.
module tb_battle_board_ctrl;
   localparam int ROWS = 7;
   localparam int COLS = 5;
   localparam int MAXS = 15;
   localparam int N    = ROWS * COLS;

   localparam int OP_LOAD     = 0;
   localparam int OP_NEXT     = 1;
   localparam int OP_FIRE     = 2;
   localparam int OP_NEXTFIRE = 3;
   localparam int OP_LOADFIRE = 4;
   localparam int OP_LOADNEXT = 5;

   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   battle_board_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) brd ();

   battle_board_ctrl #(
      .ROWS      (ROWS),
      .COLS      (COLS),
      .MAX_SHOTS (MAXS)
   ) dut (
      .clk (clk),
      .clr (clr),
      .brd (brd.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Board model: phase 0 idle, 1 playing, 2 won, 3 lost.
   bit [N-1:0] m_ship, m_hit, m_miss;
   int m_shots, m_res, m_row, m_col, m_phase, m_scan;

   typedef struct {
      int         op;
      bit [N-1:0] map;
      int         cnt;
      int         er, ec, eres, eshots;
      bit         ewin, elost;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(int op, bit [N-1:0] map, int cnt, int er, int ec,
                               int eres, int eshots, bit ewin, bit elost);
      vec_t v;
      v.op = op; v.map = map; v.cnt = cnt; v.er = er; v.ec = ec;
      v.eres = eres; v.eshots = eshots; v.ewin = ewin; v.elost = elost;
      return v;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic m_reset();
      m_ship = '0; m_hit = '0; m_miss = '0;
      m_shots = 0; m_res = 0; m_row = 0; m_col = 0; m_phase = 0; m_scan = 0;
   endtask

   task automatic m_load(input bit [N-1:0] map);
      m_ship = map; m_hit = '0; m_miss = '0;
      m_shots = MAXS; m_res = 0; m_row = 0; m_col = 0; m_phase = 1;
   endtask

   task automatic m_next();
      int lin;
      if (m_phase == 1) begin
         lin   = (m_col * ROWS + m_row + 1) % N;
         m_row = lin % ROWS;
         m_col = lin / ROWS;
      end
   endtask

   task automatic m_fire();
      int i;
      if (m_phase != 1) return;
      i = m_col * ROWS + m_row;
      if (m_hit[i] || m_miss[i]) begin
         m_res = 3;
      end else begin
         if (m_ship[i]) begin m_hit[i] = 1'b1; m_res = 2; end
         else begin m_miss[i] = 1'b1; m_res = 1; end
         if (m_shots > 0) m_shots--;
      end
      if (m_ship != '0 && (m_hit & m_ship) == m_ship) m_phase = 2;
      else if (m_shots == 0) m_phase = 3;
   endtask

   task automatic pulse(input bit ld, input bit nx, input bit fr, input bit [N-1:0] map);
      @(negedge clk);
      brd.ship_map = map;
      brd.load_map = ld;
      brd.btn_next = nx;
      brd.btn_fire = fr;
      @(negedge clk);
      brd.load_map = 1'b0;
      brd.btn_next = 1'b0;
      brd.btn_fire = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   task automatic tick();
      @(negedge clk);
      brd.scan_tick = 1'b1;
      @(negedge clk);
      brd.scan_tick = 1'b0;
      m_scan = (m_scan + 1) % COLS;
   endtask

   task automatic do_op(input int op, input bit [N-1:0] map, input int cnt);
      case (op)
         OP_LOAD:     begin pulse(1, 0, 0, map); m_load(map); end
         OP_NEXT:     for (int k = 0; k < cnt; k++) begin pulse(0, 1, 0, '0); m_next(); end
         OP_FIRE:     begin pulse(0, 0, 1, '0); m_fire(); end
         OP_NEXTFIRE: begin pulse(0, 1, 1, '0); m_fire(); end
         OP_LOADFIRE: begin pulse(1, 0, 1, map); m_load(map); end
         OP_LOADNEXT: begin pulse(1, 1, 0, map); m_load(map); end
         default: ;
      endcase
      settle();
   endtask

   task automatic compare_all(input string tag);
      bit [N-1:0]    src;
      bit [ROWS-1:0] el;
      src = brd.show_ships ? m_ship : m_hit;
      for (int r = 0; r < ROWS; r++) el[r] = ~src[m_scan*ROWS + r];
      check({tag, "_row"},   longint'(brd.cur_row),    longint'(m_row));
      check({tag, "_col"},   longint'(brd.cur_col),    longint'(m_col));
      check({tag, "_res"},   longint'(brd.result),     longint'(m_res));
      check({tag, "_shots"}, longint'(brd.shots_left), longint'(m_shots));
      check({tag, "_win"},   longint'(brd.win),        longint'(m_phase == 2));
      check({tag, "_lost"},  longint'(brd.lost),       longint'(m_phase == 3));
      check({tag, "_mcol"},  longint'(brd.m_col),      longint'(1) << m_scan);
      check({tag, "_mline"}, longint'(brd.m_line),     longint'(el));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_row"},   longint'(brd.cur_row),    0);
      check({tag, "_col"},   longint'(brd.cur_col),    0);
      check({tag, "_res"},   longint'(brd.result),     0);
      check({tag, "_shots"}, longint'(brd.shots_left), 0);
      check({tag, "_win"},   longint'(brd.win),        0);
      check({tag, "_lost"},  longint'(brd.lost),       0);
      check({tag, "_mcol"},  longint'(brd.m_col),      1);
      check({tag, "_mline"}, longint'(brd.m_line),     longint'(7'h7f));
   endtask

   initial begin
      bit [N-1:0] two = 35'b11;
      bit [N-1:0] rmap;
      int         r;

      brd.ship_map = '0; brd.load_map = 0; brd.btn_next = 0;
      brd.btn_fire = 0;  brd.show_ships = 0; brd.scan_tick = 0;
      m_reset();

      repeat (3) @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      check_reset_vals("reset");

      // Buttons are ignored while idle.
      pulse(0, 1, 0, '0);
      pulse(0, 0, 1, '0);
      settle();
      check_reset_vals("idle_ign");

      tbl[0]  = mk(OP_LOAD,     two, 0,  0, 0, 0, 15, 0, 0);
      tbl[1]  = mk(OP_FIRE,     '0,  0,  0, 0, 2, 14, 0, 0);
      tbl[2]  = mk(OP_FIRE,     '0,  0,  0, 0, 3, 14, 0, 0);
      tbl[3]  = mk(OP_NEXT,     '0,  7,  0, 1, 3, 14, 0, 0);
      tbl[4]  = mk(OP_NEXT,     '0,  28, 0, 0, 3, 14, 0, 0);
      tbl[5]  = mk(OP_NEXT,     '0,  1,  1, 0, 3, 14, 0, 0);
      tbl[6]  = mk(OP_FIRE,     '0,  0,  1, 0, 2, 13, 1, 0);
      tbl[7]  = mk(OP_FIRE,     '0,  0,  1, 0, 2, 13, 1, 0);
      tbl[8]  = mk(OP_NEXT,     '0,  1,  1, 0, 2, 13, 1, 0);
      tbl[9]  = mk(OP_LOADFIRE, two, 0,  0, 0, 0, 15, 0, 0);
      tbl[10] = mk(OP_NEXTFIRE, '0,  0,  0, 0, 2, 14, 0, 0);
      tbl[11] = mk(OP_NEXT,     '0,  2,  2, 0, 2, 14, 0, 0);
      tbl[12] = mk(OP_FIRE,     '0,  0,  2, 0, 1, 13, 0, 0);
      tbl[13] = mk(OP_NEXTFIRE, '0,  0,  2, 0, 3, 13, 0, 0);
      tbl[14] = mk(OP_LOADNEXT, two, 0,  0, 0, 0, 15, 0, 0);

      for (int i = 0; i < 15; i++) begin
         do_op(tbl[i].op, tbl[i].map, tbl[i].cnt);
         check($sformatf("v%0d_row", i),   longint'(brd.cur_row),    tbl[i].er);
         check($sformatf("v%0d_col", i),   longint'(brd.cur_col),    tbl[i].ec);
         check($sformatf("v%0d_res", i),   longint'(brd.result),     tbl[i].eres);
         check($sformatf("v%0d_shots", i), longint'(brd.shots_left), tbl[i].eshots);
         check($sformatf("v%0d_win", i),   longint'(brd.win),        longint'(tbl[i].ewin));
         check($sformatf("v%0d_lost", i),  longint'(brd.lost),       longint'(tbl[i].elost));
      end

      // Empty map: budget runs out, never won; further input is ignored.
      do_op(OP_LOAD, '0, 0);
      for (int k = 0; k < MAXS; k++) begin
         do_op(OP_FIRE, '0, 0);
         check($sformatf("loss%0d_shots", k), longint'(brd.shots_left), MAXS - 1 - k);
         check($sformatf("loss%0d_lost", k),  longint'(brd.lost), longint'(k == MAXS - 1));
         check($sformatf("loss%0d_win", k),   longint'(brd.win), 0);
         do_op(OP_NEXT, '0, 1);
      end
      do_op(OP_FIRE, '0, 0);
      check("loss_after_shots", longint'(brd.shots_left), 0);
      check("loss_after_res",   longint'(brd.result), 1);
      check("loss_after_lost",  longint'(brd.lost), 1);
      check("loss_after_row",   longint'(brd.cur_row), 0);
      check("loss_after_col",   longint'(brd.cur_col), 2);

      // Scan of the two-ship map.
      do_op(OP_LOAD, two, 0);
      brd.show_ships = 1'b1;
      while (m_scan != 0) tick();
      settle();
      check("scan_c0_mcol",  longint'(brd.m_col),  longint'(5'b00001));
      check("scan_c0_mline", longint'(brd.m_line), longint'(7'b1111100));
      for (int c = 1; c < COLS; c++) begin
         tick();
         settle();
         check($sformatf("scan_c%0d_mcol", c),  longint'(brd.m_col),  longint'(1) << c);
         check($sformatf("scan_c%0d_mline", c), longint'(brd.m_line), longint'(7'h7f));
      end
      tick();
      brd.show_ships = 1'b0;
      settle();
      check("scan_hit_c0_mline", longint'(brd.m_line), longint'(7'h7f));

      // Shot latency: result appears on the second edge after fire.
      @(negedge clk);
      brd.btn_fire = 1'b1;
      @(posedge clk);
      #1 brd.btn_fire = 1'b0;
      check("lat_e0_res", longint'(brd.result), 0);
      @(posedge clk);
      #1;
      check("lat_e1_res",   longint'(brd.result), 2);
      check("lat_e1_shots", longint'(brd.shots_left), 14);
      m_fire();
      settle();
      compare_all("lat_after");

      // Randomized operations against the model.
      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 8: begin
               rmap = '0;
               for (int k = $urandom_range(0, 3); k > 0; k--)
                  rmap[$urandom_range(0, N-1)] = 1'b1;
               do_op((r == 0) ? OP_LOAD : OP_LOADFIRE, rmap, 0);
            end
            1, 2, 3: do_op(OP_NEXT, '0, $urandom_range(1, 4));
            4, 5, 9: do_op(OP_FIRE, '0, 0);
            6:       do_op(OP_NEXTFIRE, '0, 0);
            default: begin
               brd.show_ships = 1'($urandom_range(0, 1));
               tick();
               settle();
            end
         endcase
         compare_all($sformatf("rnd%0d", i));
      end

      // Reset during CHECK: back to reset values, shot not recorded.
      do_op(OP_LOAD, two, 0);
      brd.show_ships = 1'b0;
      @(negedge clk);
      brd.btn_fire = 1'b1;
      @(negedge clk);
      brd.btn_fire = 1'b0;
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      m_reset();
      check_reset_vals("clr_check");
      do_op(OP_LOAD, two, 0);
      do_op(OP_FIRE, '0, 0);
      compare_all("clr_refire");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
